// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the BCD stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t DIGIT_MAX = 4'd9;
  localparam bcd_t TENS_MAX  = 4'd5;

endpackage

// File: rtl/stopwatch_bcd_digit_counter.sv
// One BCD digit of the live counter; wraps at LIMIT and reports carry to the next digit.
module bcd_digit_counter #(
  parameter logic [3:0] LIMIT = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] next_digit,
  output logic       carry
);

  logic [3:0] digit;

  // next_digit is exported so the top can capture the post-increment value
  // into the display register on the same edge.
  always_comb begin
    next_digit = digit;
    if (clear)
      next_digit = 4'd0;
    else if (enable)
      next_digit = (digit == LIMIT) ? 4'd0 : digit + 4'd1;
  end

  assign carry = enable && (digit == LIMIT);

  // NOTE: synchronous reset: rst_n is only sampled on the clock edge, so it sits
  // inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n)
      digit <= 4'd0;
    else
      digit <= next_digit;
  end

endmodule

// File: rtl/stopwatch_counter.sv
// BCD stopwatch MM:SS.cc driven by a toggling 10 ms tick, with start/stop, clear and lap freeze.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN_TENS = 5
) (
  input  logic       i_sclk,
  input  logic       i_reset_n,
  input  logic       i_base_tick,
  input  logic       i_startstop,
  input  logic       i_clear,
  input  logic       i_lap,
  output logic [3:0] o_cs_ones,
  output logic [3:0] o_cs_tens,
  output logic [3:0] o_sec_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_min_tens,
  output logic       o_running,
  output logic       o_lap_active,
  output logic       o_rollover
);

  state_t            state;
  state_t            state_next;
  logic              tick_d;
  logic              step;
  logic              count_en;
  logic              freeze;
  logic [5:0]        enable;
  logic [5:0]        carry;
  logic [5:0][3:0]   live_next;
  logic [5:0][3:0]   shown;
  logic              rollover;
  logic              running;
  logic              lap_active;

  // Loaded during reset as well, so a high tick at release is not seen as a step.
  always_ff @(posedge i_sclk) tick_d <= i_base_tick;

  assign step     = (i_base_tick != tick_d);
  assign count_en = step && !i_clear && ((state == RUN) || (state == LAP));

  // Display holds only while LAP persists; any command leaving or re-entering LAP reloads it.
  assign freeze = (state == LAP) && !i_clear && !i_startstop && !i_lap;

  assign enable[0] = count_en;
  assign enable[5:1] = carry[4:0];

  for (genvar i = 0; i < 6; i++) begin : g_digit
    localparam logic [3:0] LIM = (i == 3) ? TENS_MAX :
                                 (i == 5) ? 4'(MAX_MIN_TENS) : DIGIT_MAX;
    bcd_digit_counter #(.LIMIT(LIM)) u_digit (
      .clk        (i_sclk),
      .rst_n      (i_reset_n),
      .clear      (i_clear),
      .enable     (enable[i]),
      .next_digit (live_next[i]),
      .carry      (carry[i])
    );
  end

  // NOTE: every path assigns state_next a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    if (i_clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (i_startstop) state_next = RUN;
        RUN:     if (i_startstop) state_next = PAUSE;
                 else if (i_lap)  state_next = LAP;
        LAP:     if (i_startstop) state_next = PAUSE;
                 else if (i_lap)  state_next = RUN;
        PAUSE:   if (i_startstop) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: non-blocking assignments so each flop samples the values from before the edge.
  always_ff @(posedge i_sclk) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      running    <= 1'b0;
      lap_active <= 1'b0;
    end else begin
      state      <= state_next;
      running    <= (state_next == RUN) || (state_next == LAP);
      lap_active <= (state_next == LAP);
    end
  end

  always_ff @(posedge i_sclk) begin
    if (!i_reset_n) begin
      shown    <= '0;
      rollover <= 1'b0;
    end else begin
      rollover <= carry[5];
      if (!freeze)
        shown <= live_next;
    end
  end

  assign o_cs_ones    = shown[0];
  assign o_cs_tens    = shown[1];
  assign o_sec_ones   = shown[2];
  assign o_sec_tens   = shown[3];
  assign o_min_ones   = shown[4];
  assign o_min_tens   = shown[5];
  assign o_running    = running;
  assign o_lap_active = lap_active;
  assign o_rollover   = rollover;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed self-checking bench for stopwatch_counter; displayed value compared as 24-bit BCD.
module tb_stopwatch_counter;

  logic       sclk = 1'b0;
  logic       reset_n;
  logic       base_tick;
  logic       startstop;
  logic       clear;
  logic       lap;
  logic [3:0] cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens;
  logic       running, lap_active, rollover;
  logic [23:0] shown;

  int n_checks = 0;
  int n_errors = 0;

  stopwatch_counter #(.MAX_MIN_TENS(5)) dut (
    .i_sclk       (sclk),
    .i_reset_n    (reset_n),
    .i_base_tick  (base_tick),
    .i_startstop  (startstop),
    .i_clear      (clear),
    .i_lap        (lap),
    .o_cs_ones    (cs_ones),
    .o_cs_tens    (cs_tens),
    .o_sec_ones   (sec_ones),
    .o_sec_tens   (sec_tens),
    .o_min_ones   (min_ones),
    .o_min_tens   (min_tens),
    .o_running    (running),
    .o_lap_active (lap_active),
    .o_rollover   (rollover)
  );

  always #5 sclk = ~sclk;

  assign shown = {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each transition is followed by a second clock so transitions stay 2 clocks apart.
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sclk) base_tick = ~base_tick;
      @(negedge sclk);
    end
  endtask

  task automatic pulse_startstop();
    @(negedge sclk) startstop = 1'b1;
    @(negedge sclk) startstop = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge sclk) clear = 1'b1;
    @(negedge sclk) clear = 1'b0;
  endtask

  task automatic pulse_lap();
    @(negedge sclk) lap = 1'b1;
    @(negedge sclk) lap = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    base_tick = 1'b1;
    startstop = 1'b0;
    clear     = 1'b0;
    lap       = 1'b0;

    // Reset with tick high, then idle with no transitions.
    repeat (3) @(negedge sclk);
    check("reset_value", 32'(shown), 32'h000000);
    check("reset_running", 32'(running), 32'd0);
    check("reset_lap", 32'(lap_active), 32'd0);
    check("reset_rollover", 32'(rollover), 32'd0);
    reset_n = 1'b1;
    repeat (20) @(negedge sclk);
    check("idle_value", 32'(shown), 32'h000000);
    check("idle_running", 32'(running), 32'd0);

    // Start, count 1234 steps, pause, further steps ignored.
    pulse_startstop();
    check("start_running", 32'(running), 32'd1);
    steps(1234);
    check("count_1234", 32'(shown), 32'h001234);
    pulse_startstop();
    check("pause_running", 32'(running), 32'd0);
    steps(5);
    check("paused_hold", 32'(shown), 32'h001234);

    // Preload 59:59.98 while idle, then roll over.
    pulse_clear();
    check("clear_value", 32'(shown), 32'h000000);
    @(negedge sclk);
    force dut.g_digit[0].u_digit.digit = 4'd8;
    force dut.g_digit[1].u_digit.digit = 4'd9;
    force dut.g_digit[2].u_digit.digit = 4'd9;
    force dut.g_digit[3].u_digit.digit = 4'd5;
    force dut.g_digit[4].u_digit.digit = 4'd9;
    force dut.g_digit[5].u_digit.digit = 4'd5;
    @(negedge sclk);
    release dut.g_digit[0].u_digit.digit;
    release dut.g_digit[1].u_digit.digit;
    release dut.g_digit[2].u_digit.digit;
    release dut.g_digit[3].u_digit.digit;
    release dut.g_digit[4].u_digit.digit;
    release dut.g_digit[5].u_digit.digit;
    @(negedge sclk);
    check("preload", 32'(shown), 32'h595998);
    pulse_startstop();
    @(negedge sclk) base_tick = ~base_tick;
    @(negedge sclk);
    check("pre_wrap", 32'(shown), 32'h595999);
    check("pre_wrap_roll", 32'(rollover), 32'd0);
    base_tick = ~base_tick;
    @(negedge sclk);
    check("wrap_value", 32'(shown), 32'h000000);
    check("wrap_roll", 32'(rollover), 32'd1);
    @(negedge sclk);
    check("wrap_roll_end", 32'(rollover), 32'd0);
    check("wrap_running", 32'(running), 32'd1);

    // Lap freeze and release.
    pulse_clear();
    pulse_startstop();
    steps(100);
    check("lap_base", 32'(shown), 32'h000100);
    pulse_lap();
    check("lap_active", 32'(lap_active), 32'd1);
    check("lap_running", 32'(running), 32'd1);
    steps(50);
    check("lap_frozen", 32'(shown), 32'h000100);
    pulse_lap();
    check("lap_release", 32'(shown), 32'h000150);
    check("lap_inactive", 32'(lap_active), 32'd0);

    // startstop together with a step in RUN: step counts, then pause.
    pulse_clear();
    pulse_startstop();
    steps(9);
    check("pre_ss", 32'(shown), 32'h000009);
    @(negedge sclk);
    base_tick = ~base_tick;
    startstop = 1'b1;
    @(negedge sclk) startstop = 1'b0;
    check("ss_step", 32'(shown), 32'h000010);
    check("ss_paused", 32'(running), 32'd0);
    steps(3);
    check("ss_hold", 32'(shown), 32'h000010);

    // clear together with a step in RUN: step discarded.
    pulse_startstop();
    check("resume", 32'(running), 32'd1);
    @(negedge sclk);
    base_tick = ~base_tick;
    clear     = 1'b1;
    @(negedge sclk) clear = 1'b0;
    check("clr_step", 32'(shown), 32'h000000);
    check("clr_idle", 32'(running), 32'd0);

    // Reset in the middle of a run.
    pulse_startstop();
    steps(307);
    check("pre_reset", 32'(shown), 32'h000307);
    @(negedge sclk) reset_n = 1'b0;
    @(negedge sclk);
    check("mid_reset_value", 32'(shown), 32'h000000);
    check("mid_reset_running", 32'(running), 32'd0);
    reset_n = 1'b1;
    steps(2);
    check("post_reset_idle", 32'(shown), 32'h000000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
